vga_output_stage: RTL and testbench

Parametrised VGA timing and output-register stage for the game core. It replaces the fixed 640x480, 2-bit-per-channel raster logic with configurable timing, colour depth, sync polarity and a pixel-clock enable. It publishes the current pixel coordinate so the game logic can compute colour combinationally. It then registers colour and syncs together so the pins change on the same edge, with colour forced to zero outside the active area.

---
 rtl/vga_output_stage.sv | 136 +++++++++++++
 tb/tb_vga_output_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_output_stage.sv
// vga_output_stage: parametrised VGA raster counters plus the colour/sync output register.
// Latency: colour and syncs for coordinate (o_x, o_y) reach the pins 1 enabled clk later.
// Backpressure: none; i_enable low freezes counters and output registers.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   i_enable                 pixel enable; nothing advances while low
//   o_x, o_y                 current raster coordinate for the game logic
//   o_active                 coordinate lies inside the visible area
//   o_line_start             enabled cycle at x == 0
//   o_frame_start            enabled cycle at x == 0, y == 0
//   i_r, i_g, i_b            colour for the coordinate on o_x / o_y
//   o_vga_r/g/b              registered colour, zero outside the visible area
//   o_vga_hsync, o_vga_vsync registered syncs, aligned with colour
module vga_output_stage #(
  parameter int COLOR_BITS = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_POL   = 0
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  i_enable,
  output logic [$clog2(H_ACTIVE+H_FRONT+H_SYNC+H_BACK)-1:0]    o_x,
  output logic [$clog2(V_ACTIVE+V_FRONT+V_SYNC+V_BACK)-1:0]    o_y,
  output logic                                                  o_active,
  output logic                                                  o_line_start,
  output logic                                                  o_frame_start,
  input  logic [COLOR_BITS-1:0]                                 i_r,
  input  logic [COLOR_BITS-1:0]                                 i_g,
  input  logic [COLOR_BITS-1:0]                                 i_b,
  output logic [COLOR_BITS-1:0]                                 o_vga_r,
  output logic [COLOR_BITS-1:0]                                 o_vga_g,
  output logic [COLOR_BITS-1:0]                                 o_vga_b,
  output logic                                                  o_vga_hsync,
  output logic                                                  o_vga_vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FRONT);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FRONT);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FRONT + V_SYNC);

  // Asserted sync level; the idle level is its complement.
  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [XW-1:0]         h_cnt_q, h_cnt_d;
  logic [YW-1:0]         v_cnt_q, v_cnt_d;
  logic [COLOR_BITS-1:0] r_q, r_d;
  logic [COLOR_BITS-1:0] g_q, g_d;
  logic [COLOR_BITS-1:0] b_q, b_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;

  logic h_wrap;
  logic active;
  logic hs_act;
  logic vs_act;

  always_comb begin
    h_wrap = (h_cnt_q == H_LAST);
    active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_act = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_act = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;

    if (i_enable) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      // Vertical count moves only on the last pixel of a line.
      if (h_wrap) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end
      // Colour is sampled for the coordinate currently published, so the
      // pins show pixel (x, y) one enabled edge after o_x/o_y = (x, y).
      r_d     = active ? i_r : '0;
      g_d     = active ? i_g : '0;
      b_d     = active ? i_b : '0;
      hsync_d = hs_act ? SYNC_ON : ~SYNC_ON;
      vsync_d = vs_act ? SYNC_ON : ~SYNC_ON;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hsync_q <= ~SYNC_ON;
      vsync_q <= ~SYNC_ON;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign o_x           = h_cnt_q;
  assign o_y           = v_cnt_q;
  assign o_active      = active;
  assign o_line_start  = i_enable && (h_cnt_q == '0);
  assign o_frame_start = i_enable && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign o_vga_r       = r_q;
  assign o_vga_g       = g_q;
  assign o_vga_b       = b_q;
  assign o_vga_hsync   = hsync_q;
  assign o_vga_vsync   = vsync_q;

endmodule

// File: tb/tb_vga_output_stage.sv
// tb_vga_output_stage: drives a default 640x480 instance and a small 14x7 instance.
// Expected raster state comes from a count of enabled edges since reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_vga_output_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- default instance (A) ----------------
  logic       rst_a;
  logic       en_a = 1'b0;
  logic [1:0] r_a = '0, g_a = '0, b_a = '0;
  logic [9:0] x_a;
  logic [9:0] y_a;
  logic       act_a, ls_a, fs_a, hs_a, vs_a;
  logic [1:0] vr_a, vg_a, vb_a;

  vga_output_stage dut_a (
    .clk(clk), .rst(rst_a), .i_enable(en_a),
    .o_x(x_a), .o_y(y_a), .o_active(act_a),
    .o_line_start(ls_a), .o_frame_start(fs_a),
    .i_r(r_a), .i_g(g_a), .i_b(b_a),
    .o_vga_r(vr_a), .o_vga_g(vg_a), .o_vga_b(vb_a),
    .o_vga_hsync(hs_a), .o_vga_vsync(vs_a)
  );

  // ---------------- small instance (B) ----------------
  logic       rst_b;
  logic       en_b = 1'b0;
  logic [3:0] r_b = '0, g_b = '0, b_b = '0;
  logic [3:0] x_b;
  logic [2:0] y_b;
  logic       act_b, ls_b, fs_b, hs_b, vs_b;
  logic [3:0] vr_b, vg_b, vb_b;

  vga_output_stage #(
    .COLOR_BITS(4),
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .i_enable(en_b),
    .o_x(x_b), .o_y(y_b), .o_active(act_b),
    .o_line_start(ls_b), .o_frame_start(fs_b),
    .i_r(r_b), .i_g(g_b), .i_b(b_b),
    .o_vga_r(vr_b), .o_vga_g(vg_b), .o_vga_b(vb_b),
    .o_vga_hsync(hs_b), .o_vga_vsync(vs_b)
  );

  // ---------------- reference model A ----------------
  // Raster position is just (enabled edges since reset) folded by line and frame size.
  int         na = 0;
  int         cyc_a = 0;
  int         last_ls_a = -1;
  bit         meas_a = 1'b0;
  logic [1:0] er_a = '0, eg_a = '0, eb_a = '0;
  logic       ehs_a = 1'b1, evs_a = 1'b1;

  task automatic step_a(input bit en, input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
    int  x, y;
    bit  vis;
    en_a = en; r_a = r; g_a = g; b_a = b;
    #1;
    x   = na % 800;
    y   = (na / 800) % 525;
    vis = (x < 640) && (y < 480);
    chk("a_x", 32'(x_a), x);
    chk("a_y", 32'(y_a), y);
    chk("a_active", 32'(act_a), 32'(vis));
    chk("a_line_start", 32'(ls_a), 32'(en && x == 0));
    chk("a_frame_start", 32'(fs_a), 32'(en && x == 0 && y == 0));
    chk("a_r", 32'(vr_a), 32'(er_a));
    chk("a_g", 32'(vg_a), 32'(eg_a));
    chk("a_b", 32'(vb_a), 32'(eb_a));
    chk("a_hsync", 32'(hs_a), 32'(ehs_a));
    chk("a_vsync", 32'(vs_a), 32'(evs_a));
    if (meas_a && en && ls_a) begin
      if (last_ls_a >= 0) chk("a_line_period", 32'(cyc_a - last_ls_a), 1600);
      last_ls_a = cyc_a;
    end
    if (en) begin
      er_a  = vis ? r : 2'd0;
      eg_a  = vis ? g : 2'd0;
      eb_a  = vis ? b : 2'd0;
      ehs_a = !(x >= 656 && x < 752);
      evs_a = !(y >= 490 && y < 492);
      na++;
    end
    cyc_a++;
    @(negedge clk);
  endtask

  // ---------------- reference model B ----------------
  int         nb = 0;
  int         cyc_b = 0;
  int         last_fs_b = -1;
  bit         meas_b = 1'b0;
  logic [3:0] er_b = '0, eg_b = '0, eb_b = '0;
  logic       ehs_b = 1'b0, evs_b = 1'b0;

  task automatic reset_model_b();
    nb = 0; er_b = '0; eg_b = '0; eb_b = '0; ehs_b = 1'b0; evs_b = 1'b0;
  endtask

  task automatic step_b(input bit en, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    int x, y;
    bit vis;
    en_b = en; r_b = r; g_b = g; b_b = b;
    #1;
    x   = nb % 14;
    y   = (nb / 14) % 7;
    vis = (x < 8) && (y < 4);
    chk("b_x", 32'(x_b), x);
    chk("b_y", 32'(y_b), y);
    chk("b_active", 32'(act_b), 32'(vis));
    chk("b_line_start", 32'(ls_b), 32'(en && x == 0));
    chk("b_frame_start", 32'(fs_b), 32'(en && x == 0 && y == 0));
    chk("b_r", 32'(vr_b), 32'(er_b));
    chk("b_g", 32'(vg_b), 32'(eg_b));
    chk("b_b", 32'(vb_b), 32'(eb_b));
    chk("b_hsync", 32'(hs_b), 32'(ehs_b));
    chk("b_vsync", 32'(vs_b), 32'(evs_b));
    if (meas_b && en && fs_b) begin
      if (last_fs_b >= 0) chk("b_frame_period", 32'(cyc_b - last_fs_b), 98);
      last_fs_b = cyc_b;
    end
    if (en) begin
      er_b  = vis ? r : 4'd0;
      eg_b  = vis ? g : 4'd0;
      eb_b  = vis ? b : 4'd0;
      ehs_b = (x >= 10 && x < 12);
      evs_b = (y == 5);
      nb++;
    end
    cyc_b++;
    @(negedge clk);
  endtask

  function automatic logic [3:0] rnd4();
    // Bias toward all-ones so full-width colour is exercised often.
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    bit found;

    // Reset with no clock edge yet.
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    chk("a_rst_x", 32'(x_a), 0);
    chk("a_rst_y", 32'(y_a), 0);
    chk("a_rst_rgb", {22'd0, vr_a, vg_a, vb_a, hs_a, vs_a}, 32'b11);
    chk("b_rst_x", 32'(x_b), 0);
    chk("b_rst_y", 32'(y_b), 0);
    chk("b_rst_rgb", {18'd0, vr_b, vg_b, vb_b, hs_b, vs_b}, 32'b00);

    @(negedge clk);
    rst_a = 1'b0;

    // Line 0 with constant full-scale colour: 3 in the active area, 0 in blanking.
    for (int i = 0; i < 800; i++) step_a(1'b1, 2'd3, 2'd3, 2'd3);
    // Continuous enable with random colour.
    for (int i = 0; i < 900; i++)
      step_a(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    // Enable on every other clock: one line must take 1600 clocks.
    meas_a = 1'b1;
    last_ls_a = -1;
    for (int i = 0; i < 3300; i++)
      step_a(i % 2 == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    meas_a = 1'b0;
    // Arbitrary enable pattern.
    for (int i = 0; i < 600; i++)
      step_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    // Small instance: several full frames with continuous enable.
    rst_b = 1'b0;
    reset_model_b();
    meas_b = 1'b1;
    last_fs_b = -1;
    for (int i = 0; i < 3 * 98 + 5; i++) step_b(1'b1, rnd4(), rnd4(), rnd4());
    meas_b = 1'b0;
    for (int i = 0; i < 300; i++) step_b(1'($urandom_range(0, 1)), rnd4(), rnd4(), rnd4());

    // Advance to h = 5 on a visible line, then reset mid-line without a clock edge.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (x_b == 4'd5 && y_b < 3'd4) found = 1'b1;
      else step_b(1'b1, rnd4(), rnd4(), rnd4());
    end
    chk("b_reach_h5", 32'(found), 1);
    rst_b = 1'b1;
    #1;
    chk("b_midrst_x", 32'(x_b), 0);
    chk("b_midrst_y", 32'(y_b), 0);
    chk("b_midrst_rgb", {18'd0, vr_b, vg_b, vb_b, hs_b, vs_b}, 32'b00);
    @(negedge clk);
    rst_b = 1'b0;
    reset_model_b();
    for (int i = 0; i < 120; i++) step_b(1'b1, rnd4(), rnd4(), rnd4());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
